// File: rtl/pipe_hazard_ctrl.sv
// Stall/clear controller for an N-stage in-order pipeline: stall priority, control-flow shadow FSM,
// stall watchdog, and optional performance counters (enabled by defining PIPE_HAZARD_PERF_EN).
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES    = 5,
    parameter int RESOLVE_DEPTH = 3,
    parameter int TIMEOUT       = 255,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_STAGES-1:0] stage_stall_req,
    input  logic                  cf_dec,
    input  logic                  redirect,
    input  logic                  redirect_flush,
`ifdef PIPE_HAZARD_PERF_EN
    input  logic                  perf_clr,
    output logic [CNT_W-1:0]      perf_stall_cycles,
    output logic [CNT_W-1:0]      perf_flushes,
`endif
    output logic                  stall_pc,
    output logic [NUM_STAGES-2:0] stall_reg,
    output logic [NUM_STAGES-2:0] clear_reg,
    output logic                  shadow,
    output logic                  timeout_err
);

    localparam int NR   = NUM_STAGES - 1;
    localparam int SH_W = $clog2(RESOLVE_DEPTH + 1);
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_SHADOW = 1'b1;

    // Registers 0..RESOLVE_DEPTH-1 hold the instructions younger than the resolving one.
    localparam logic [NR-1:0] FLUSH_MASK = {NR{1'b1}} >> (NR - RESOLVE_DEPTH);

    logic            stalled;
    logic [NR-1:0]   rule_stall;
    logic [NR-1:0]   rule_clr;
    logic [NR-1:0]   fsm_clr;

    logic            state_reg;
    logic            state_next;
    logic [SH_W-1:0] sh_cnt_reg;
    logic [SH_W-1:0] sh_cnt_next;

    assign stalled = |stage_stall_req;

    // Register k is held when any older stage (index > k) is stuck; the highest
    // stuck stage below WB gets a bubble so its result is not duplicated downstream.
    genvar gi;
    generate
        for (gi = 0; gi < NR; gi++) begin : g_rule
            assign rule_stall[gi] = |stage_stall_req[NUM_STAGES-1:gi+1];
            assign rule_clr[gi]   = stage_stall_req[gi] & ~rule_stall[gi];
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        sh_cnt_next = sh_cnt_reg;
        fsm_clr     = '0;
        if (!stalled) begin
            case (state_reg)
                ST_RUN: begin
                    if (redirect && redirect_flush) begin
                        fsm_clr = FLUSH_MASK;
                    end else if (cf_dec) begin
                        fsm_clr[0]  = 1'b1;
                        state_next  = ST_SHADOW;
                        sh_cnt_next = SH_W'(RESOLVE_DEPTH);
                    end
                end
                ST_SHADOW: begin
                    fsm_clr[0] = 1'b1;
                    if (redirect || (sh_cnt_reg <= SH_W'(1))) begin
                        state_next  = ST_RUN;
                        sh_cnt_next = '0;
                    end else begin
                        sh_cnt_next = sh_cnt_reg - SH_W'(1);
                    end
                end
                default: begin
                    state_next  = ST_RUN;
                    sh_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= ST_RUN;
            sh_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            sh_cnt_reg <= sh_cnt_next;
        end
    end

    always_comb begin
        stall_pc  = 1'b0;
        stall_reg = '0;
        clear_reg = '0;
        if (reset_n) begin
            if (stalled) begin
                stall_pc  = 1'b1;
                stall_reg = rule_stall;
                clear_reg = rule_clr;
            end else begin
                clear_reg = fsm_clr;
            end
        end
    end

    assign shadow = (state_reg == ST_SHADOW);

    generate
        if (TIMEOUT > 0) begin : g_wd
            logic [WD_W-1:0] wd_cnt_reg;
            logic            wd_err_reg;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    wd_cnt_reg <= '0;
                    wd_err_reg <= 1'b0;
                end else if (stalled) begin
                    if (wd_cnt_reg != WD_W'(TIMEOUT)) begin
                        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
                    end
                    if (wd_cnt_reg >= WD_W'(TIMEOUT - 1)) begin
                        wd_err_reg <= 1'b1;
                    end
                end else begin
                    wd_cnt_reg <= '0;
                end
            end

            assign timeout_err = wd_err_reg;
        end else begin : g_no_wd
            assign timeout_err = 1'b0;
        end
    endgenerate

`ifdef PIPE_HAZARD_PERF_EN
    logic             flush_evt;
    logic [CNT_W-1:0] perf_stall_reg;
    logic [CNT_W-1:0] perf_flush_reg;

    assign flush_evt = !stalled && (state_reg == ST_RUN) && (cf_dec || (redirect && redirect_flush));

    always_ff @(posedge clk) begin
        if (!reset_n || perf_clr) begin
            perf_stall_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if (stalled && !(&perf_stall_reg)) begin
                perf_stall_reg <= perf_stall_reg + CNT_W'(1);
            end
            if (flush_evt && !(&perf_flush_reg)) begin
                perf_flush_reg <= perf_flush_reg + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cycles = perf_stall_reg;
    assign perf_flushes      = perf_flush_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl (5 stages, resolve depth 3, watchdog timeout 4);
// each cycle's expected outputs go through a scoreboard queue before being compared.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset_n;
    logic [4:0] stage_stall_req;
    logic       cf_dec;
    logic       redirect;
    logic       redirect_flush;
    logic       stall_pc;
    logic [3:0] stall_reg;
    logic [3:0] clear_reg;
    logic       shadow;
    logic       timeout_err;
`ifdef PIPE_HAZARD_PERF_EN
    logic        perf_clr;
    logic [15:0] perf_stall_cycles;
    logic [15:0] perf_flushes;
`endif

    pipe_hazard_ctrl #(
        .NUM_STAGES   (5),
        .RESOLVE_DEPTH(3),
        .TIMEOUT      (4),
        .CNT_W        (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stage_stall_req(stage_stall_req),
        .cf_dec         (cf_dec),
        .redirect       (redirect),
        .redirect_flush (redirect_flush),
`ifdef PIPE_HAZARD_PERF_EN
        .perf_clr         (perf_clr),
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flushes     (perf_flushes),
`endif
        .stall_pc       (stall_pc),
        .stall_reg      (stall_reg),
        .clear_reg      (clear_reg),
        .shadow         (shadow),
        .timeout_err    (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       rn;
        logic [4:0] req;
        logic       cf;
        logic       rd;
        logic       rf;
    } in_t;

    typedef struct packed {
        logic       pc;
        logic [3:0] sreg;
        logic [3:0] clr;
        logic       sh;
        logic       te;
    } exp_t;

    typedef struct packed {
        in_t  in;
        exp_t exp;
    } vec_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    function automatic vec_t mk(input logic rn, input logic [4:0] req, input logic cf, input logic rd,
                                input logic rf, input logic pc, input logic [3:0] sreg,
                                input logic [3:0] clr, input logic sh, input logic te);
        vec_t v;
        v.in.rn    = rn;
        v.in.req   = req;
        v.in.cf    = cf;
        v.in.rd    = rd;
        v.in.rf    = rf;
        v.exp.pc   = pc;
        v.exp.sreg = sreg;
        v.exp.clr  = clr;
        v.exp.sh   = sh;
        v.exp.te   = te;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s txn %0d: got %0h expected %0h", name, idx, act, req);
        end
    endtask

    // Called one time unit after a rising edge; returns one time unit after the next rising edge.
    task automatic run_cycle(input vec_t v);
        exp_t e;
        reset_n         = v.in.rn;
        stage_stall_req = v.in.req;
        cf_dec          = v.in.cf;
        redirect        = v.in.rd;
        redirect_flush  = v.in.rf;
        exp_q.push_back(v.exp);
        #3;
        e = exp_q.pop_front();
        $display("txn %0d rn=%b req=%b cf=%b rd=%b rf=%b -> pc=%b sreg=%b clr=%b sh=%b te=%b",
                 txn, v.in.rn, v.in.req, v.in.cf, v.in.rd, v.in.rf,
                 stall_pc, stall_reg, clear_reg, shadow, timeout_err);
        check("stall_pc", txn, 32'(stall_pc), 32'(e.pc));
        check("stall_reg", txn, 32'(stall_reg), 32'(e.sreg));
        check("clear_reg", txn, 32'(clear_reg), 32'(e.clr));
        check("shadow", txn, 32'(shadow), 32'(e.sh));
        check("timeout_err", txn, 32'(timeout_err), 32'(e.te));
        txn++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                rn  req       cf rd rf  pc sreg     clr      sh te
        tbl.push_back(mk(0, 5'b11111, 1, 0, 0,  0, 4'b0000, 4'b0000, 0, 0)); // reset forces zeros
        tbl.push_back(mk(1, 5'b01000, 0, 0, 0,  1, 4'b0111, 4'b1000, 0, 0));
        tbl.push_back(mk(1, 5'b01000, 0, 0, 0,  1, 4'b0111, 4'b1000, 0, 0));
        tbl.push_back(mk(1, 5'b01000, 0, 0, 0,  1, 4'b0111, 4'b1000, 0, 0));
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 5'b10001, 0, 0, 0,  1, 4'b1111, 4'b0000, 0, 0)); // WB dominates
        tbl.push_back(mk(1, 5'b00001, 0, 0, 0,  1, 4'b0000, 4'b0001, 0, 0));
        tbl.push_back(mk(1, 5'b00100, 0, 0, 0,  1, 4'b0011, 4'b0100, 0, 0));
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 5'b00000, 1, 0, 0,  0, 4'b0000, 4'b0001, 0, 0)); // shadow entry
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0001, 1, 0));
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0001, 1, 0));
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0001, 1, 0));
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 5'b00000, 1, 0, 0,  0, 4'b0000, 4'b0001, 0, 0)); // shadow with 2 stalls
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0001, 1, 0));
        tbl.push_back(mk(1, 5'b00010, 0, 0, 0,  1, 4'b0001, 4'b0010, 1, 0));
        tbl.push_back(mk(1, 5'b00010, 0, 0, 0,  1, 4'b0001, 4'b0010, 1, 0));
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0001, 1, 0));
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0001, 1, 0));
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 5'b00000, 1, 0, 0,  0, 4'b0000, 4'b0001, 0, 0)); // shadow ended by redirect
        tbl.push_back(mk(1, 5'b00000, 1, 0, 0,  0, 4'b0000, 4'b0001, 1, 0)); // cf_dec ignored
        tbl.push_back(mk(1, 5'b00000, 0, 1, 1,  0, 4'b0000, 4'b0001, 1, 0));
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 5'b00000, 1, 1, 1,  0, 4'b0000, 4'b0111, 0, 0)); // redirect beats cf_dec
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 5'b00000, 0, 1, 0,  0, 4'b0000, 4'b0000, 0, 0)); // redirect without flush
        tbl.push_back(mk(1, 5'b00001, 0, 1, 1,  1, 4'b0000, 4'b0001, 0, 0)); // stalled: redirect ignored
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0));

        reset_n         = 1'b0;
        stage_stall_req = '0;
        cf_dec          = 1'b0;
        redirect        = 1'b0;
        redirect_flush  = 1'b0;
`ifdef PIPE_HAZARD_PERF_EN
        perf_clr        = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) run_cycle(tbl[i]);

`ifdef PIPE_HAZARD_PERF_EN
        check("perf_stall_cycles", txn, 32'(perf_stall_cycles), 32'd9);
        check("perf_flushes", txn, 32'(perf_flushes), 32'd4);
`endif

        // Reset in the middle of a shadow abandons it.
        run_cycle(mk(1, 5'b00000, 1, 0, 0,  0, 4'b0000, 4'b0001, 0, 0));
        run_cycle(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0001, 1, 0));
        run_cycle(mk(0, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 1, 0));
        run_cycle(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0));

`ifdef PIPE_HAZARD_PERF_EN
        perf_clr = 1'b1;
        run_cycle(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0));
        perf_clr = 1'b0;
        check("perf_clr", txn, 32'(perf_flushes), 32'd0);
`endif

        // Watchdog: four consecutive stalled cycles trip it at the fourth edge.
        for (int k = 0; k < 4; k++) begin
            run_cycle(mk(1, 5'b00001, 0, 0, 0,  1, 4'b0000, 4'b0001, 0, 0));
        end
`ifdef PIPE_HAZARD_PERF_EN
        check("perf_stall_cycles_wd", txn, 32'(perf_stall_cycles), 32'd4);
`endif
        run_cycle(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 1));
        run_cycle(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 1)); // sticky
        run_cycle(mk(0, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 1));
        run_cycle(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0)); // cleared by reset

        // Three stalls after an unstalled gap must not trip the watchdog.
        for (int k = 0; k < 3; k++) begin
            run_cycle(mk(1, 5'b10000, 0, 0, 0,  1, 4'b1111, 4'b0000, 0, 0));
        end
        run_cycle(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0));
        run_cycle(mk(1, 5'b10000, 0, 0, 0,  1, 4'b1111, 4'b0000, 0, 0));
        run_cycle(mk(1, 5'b00000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised successor to the LC-3b pipeline stall unit. It drives per-register stall and clear controls for an N-stage pipeline.
- Inputs: generic per-stage stall requests (memory waits, load-use) and control-flow events from ID and the resolving stage.
- Adds a registered control-flow shadow FSM, a redirect flush for predicted branches, a stall watchdog and optional performance counters.
- Sits beside the datapath. Its outputs feed the PC and every inter-stage register.

Parameters:
- NUM_STAGES, 5, number of pipeline stages. Stage 0 = IF, NUM_STAGES-1 = WB. Pipeline register k sits between stage k and stage k+1.
- RESOLVE_DEPTH, 3, cycles from ID decode to control-flow resolution. Legal range 1..NUM_STAGES-1.
- TIMEOUT, 255, consecutive stall cycles before the watchdog trips. 0 disables the watchdog.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- stage_stall_req  in  NUM_STAGES  bit i: stage i cannot complete this cycle.
- cf_dec  in  1  ID holds an unpredicted control-flow instruction (jmp/jsr/trap, or br when prediction is off).
- redirect  in  1  control flow resolved this cycle; PC is being redirected.
- redirect_flush  in  1  qualifies redirect; younger instructions must be squashed (taken or mispredicted).
- stall_pc  out  1  hold PC.
- stall_reg  out  NUM_STAGES-1  hold pipeline register k.
- clear_reg  out  NUM_STAGES-1  load a bubble into pipeline register k.
- shadow  out  1  FSM is in SHADOW.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- Reset (reset_n=0 at an edge):
  - FSM enters RUN; shadow counter, watchdog counter, timeout_err and perf counters go to 0.
  - While reset_n=0, all stall/clear outputs are forced to 0.
  - Reset mid-shadow or mid-stall abandons the operation immediately.
- Stall priority (combinational, same cycle):
  - s = highest set index of stage_stall_req.
  - If s = NUM_STAGES-1: stall_pc and all stall_reg are 1; no clears.
  - Otherwise: stall_pc=1, stall_reg[0..s-1]=1, clear_reg[s]=1.
  - No request: no stalls.
- "Stalled cycle" means any stage_stall_req bit is set. During a stalled cycle:
  - the FSM and shadow counter hold;
  - redirect and cf_dec are ignored, and producers hold them until an unstalled cycle;
  - only the stall-rule outputs are driven.
- FSM (registered, 2 states):
  - RUN: if redirect & redirect_flush, clear_reg[0..RESOLVE_DEPTH-1]=1 for that cycle and stay in RUN. This covers predicted-branch mispredicts.
  - RUN: else if cf_dec, go to SHADOW and load the counter with RESOLVE_DEPTH. In the entry cycle clear_reg[0]=1; PC is not stalled.
  - RUN: redirect and cf_dec in the same cycle → redirect wins (it kills the ID instruction); stay in RUN.
  - SHADOW: clear_reg[0]=1 every unstalled cycle. Fetched instructions are squashed while the PC keeps advancing.
  - SHADOW: counter decrements on each unstalled cycle.
  - SHADOW: redirect → clear_reg[0]=1 that cycle, go to RUN.
  - SHADOW: counter reaching 0 without a redirect → go to RUN (not-taken fallthrough).
  - SHADOW: cf_dec is ignored.
- Watchdog:
  - Counter width = clog2(TIMEOUT+1).
  - Increments each stalled cycle and clears on any unstalled cycle.
  - On reaching TIMEOUT it sets timeout_err=1 and saturates.
  - timeout_err stays 1 until reset.
- Outputs are combinational from inputs and registered state. No added latency.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined: adds input perf_clr (1, synchronous clear) and two outputs, each saturating and cleared by reset or perf_clr:
  - perf_stall_cycles (CNT_W): increments each stalled cycle.
  - perf_flushes (CNT_W): increments on each RUN→SHADOW entry and on each RUN redirect_flush.
- Undefined: those ports and counters are absent; all other behaviour is unchanged.

Test Plan:
- stage_stall_req=5'b01000 for 3 cycles (defaults) → stall_pc=1, stall_reg=4'b0111, clear_reg=4'b1000 each cycle. Removing the request → all outputs 0 next cycle.
- stage_stall_req=5'b10001 → stall_pc=1, stall_reg=4'b1111, clear_reg=4'b0000 (WB stall dominates the IF stall).
- cf_dec pulse, no redirect:
  - shadow=1 for 3 cycles, clear_reg[0]=1 in the entry cycle plus 3 shadow cycles, then RUN.
  - Inserting 2 stalled cycles mid-shadow extends it to 5 cycles.
- cf_dec, then redirect 2 cycles later → shadow drops after the redirect cycle. cf_dec again while in SHADOW → no effect.
- In RUN: redirect=1, redirect_flush=1 together with cf_dec=1 → clear_reg=4'b0111 one cycle, shadow stays 0.
- TIMEOUT=4, stage_stall_req[0] held 4 cycles → timeout_err=1 at the 4th edge and stays 1 after the request drops, until reset_n=0. With PIPE_HAZARD_PERF_EN: perf_stall_cycles=4.
